// File: rtl/updn_mod_counter_if.sv
// Signal bundle for updn_mod_counter: the control inputs and the count/terminal-count outputs.
// The master side drives the controls and the slave side (the counter) drives the results.
interface updn_mod_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              enable_cnt_up;
    logic              enable_cnt_dn;
    logic              pause_counting;
    logic              new_cntr_preset;
    logic [WIDTH-1:0]  new_cntr_preset_value;
    logic [WIDTH-1:0]  limit_value;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic [WIDTH-1:0]  count_value;
    logic              tc_up;
    logic              tc_dn;
    logic              at_max;
    logic              at_min;
    logic [7:0]        wrap_count;

    modport master (
        output enable_cnt_up, enable_cnt_dn, pause_counting, new_cntr_preset,
               new_cntr_preset_value, limit_value, step, sat_mode,
        input  count_value, tc_up, tc_dn, at_max, at_min, wrap_count
    );

    modport slave (
        input  enable_cnt_up, enable_cnt_dn, pause_counting, new_cntr_preset,
               new_cntr_preset_value, limit_value, step, sat_mode,
        output count_value, tc_up, tc_dn, at_max, at_min, wrap_count
    );
endinterface

// File: rtl/updn_mod_counter.sv
// Up/down counter with programmable limit, step, wrap/saturate mode, preset and pause.
// Define UPDN_WRAP_CNT_EN to build the saturating 8-bit wrap-event counter on wrap_count.
module updn_mod_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    updn_mod_counter_if.slave bus
);
    // Two guard bits keep count+step and count+limit+1 exact before any compare.
    localparam int EXT_W = WIDTH + 2;
    typedef logic [EXT_W-1:0] ext_t;
    localparam ext_t ONE = ext_t'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_up_q;
    logic             tc_up_d;
    logic             tc_dn_q;
    logic             tc_dn_d;

    ext_t cnt_x;
    ext_t lim_x;
    ext_t step_x;
    ext_t sum_x;
    ext_t up_wrap_x;
    ext_t dn_diff_x;
    ext_t dn_base_x;
    ext_t dn_wrap_x;
    logic do_count;

    assign cnt_x     = ext_t'(count_q);
    assign lim_x     = ext_t'(bus.limit_value);
    assign step_x    = ext_t'(bus.step);
    assign sum_x     = cnt_x + step_x;
    assign up_wrap_x = sum_x - (lim_x + ONE);
    assign dn_diff_x = cnt_x - step_x;
    assign dn_base_x = cnt_x + lim_x + ONE;
    assign dn_wrap_x = dn_base_x - step_x;

    // Exactly one direction requested, a non-zero step, and not paused.
    assign do_count = !bus.pause_counting
                   && (bus.enable_cnt_up ^ bus.enable_cnt_dn)
                   && (bus.step != '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_d = count_q;
        tc_up_d = 1'b0;
        tc_dn_d = 1'b0;

        if (bus.new_cntr_preset) begin
            count_d = (bus.new_cntr_preset_value > bus.limit_value)
                    ? bus.limit_value : bus.new_cntr_preset_value;
        end else if (do_count) begin
            if (cnt_x > lim_x) begin
                // Limit was lowered under the count: snap back into range.
                if (bus.enable_cnt_up) begin
                    count_d = '0;
                    tc_up_d = 1'b1;
                end else begin
                    count_d = bus.limit_value;
                    tc_dn_d = 1'b1;
                end
            end else if (bus.enable_cnt_up) begin
                if (sum_x <= lim_x) begin
                    count_d = sum_x[WIDTH-1:0];
                end else if (bus.sat_mode) begin
                    count_d = bus.limit_value;
                    tc_up_d = (cnt_x < lim_x);
                end else begin
                    count_d = (up_wrap_x > lim_x) ? '0 : up_wrap_x[WIDTH-1:0];
                    tc_up_d = 1'b1;
                end
            end else begin
                if (cnt_x >= step_x) begin
                    count_d = dn_diff_x[WIDTH-1:0];
                end else if (bus.sat_mode) begin
                    count_d = '0;
                    tc_dn_d = (count_q != '0);
                end else begin
                    // A negative wrapped result clamps to zero.
                    count_d = (dn_base_x >= step_x) ? dn_wrap_x[WIDTH-1:0] : '0;
                    tc_dn_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_up_q <= 1'b0;
            tc_dn_q <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_up_q <= tc_up_d;
            tc_dn_q <= tc_dn_d;
        end
    end

`ifdef UPDN_WRAP_CNT_EN
    logic [7:0] wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= '0;
        end else if ((tc_up_d || tc_dn_d) && (wrap_q != 8'hFF)) begin
            wrap_q <= wrap_q + 8'd1;
        end
    end

    assign bus.wrap_count = wrap_q;
`else
    assign bus.wrap_count = 8'd0;
`endif

    assign bus.count_value = count_q;
    assign bus.tc_up       = tc_up_q;
    assign bus.tc_dn       = tc_dn_q;
    assign bus.at_max      = (count_q == bus.limit_value);
    assign bus.at_min      = (count_q == '0);
endmodule

// File: tb/tb_updn_mod_counter.sv
// Self-checking bench for updn_mod_counter: directed scenarios plus randomized traffic
// compared against an integer reference model of the counting rules.
module tb_updn_mod_counter;
    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
`ifdef UPDN_WRAP_CNT_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    updn_mod_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    updn_mod_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_count = 0;
    int m_tc_up = 0;
    int m_tc_dn = 0;
    int m_wrap  = 0;

    task automatic drive(input bit r, input bit up, input bit dn, input bit pause,
                         input bit pre, input int pre_val, input int lim,
                         input int stp, input bit sat);
        rst                       = r;
        bus.enable_cnt_up         = up;
        bus.enable_cnt_dn         = dn;
        bus.pause_counting        = pause;
        bus.new_cntr_preset       = pre;
        bus.new_cntr_preset_value = WIDTH'(pre_val);
        bus.limit_value           = WIDTH'(lim);
        bus.step                  = STEP_W'(stp);
        bus.sat_mode              = sat;
    endtask

    // Apply the counting rules to the currently driven inputs.
    task automatic model_update();
        int c   = m_count;
        int lim = int'(bus.limit_value);
        int stp = int'(bus.step);
        int pv  = int'(bus.new_cntr_preset_value);
        int n   = m_count;
        bit tu  = 1'b0;
        bit td  = 1'b0;
        if (rst) begin
            m_count = 0; m_tc_up = 0; m_tc_dn = 0; m_wrap = 0;
            return;
        end
        if (bus.new_cntr_preset) begin
            n = (pv > lim) ? lim : pv;
        end else if (!bus.pause_counting && (bus.enable_cnt_up != bus.enable_cnt_dn) && stp != 0) begin
            if (c > lim) begin
                if (bus.enable_cnt_up) begin n = 0; tu = 1'b1; end
                else begin n = lim; td = 1'b1; end
            end else if (bus.enable_cnt_up) begin
                n = c + stp;
                if (n > lim) begin
                    if (bus.sat_mode) begin tu = (c < lim); n = lim; end
                    else begin n = n - (lim + 1); if (n > lim) n = 0; tu = 1'b1; end
                end
            end else begin
                n = c - stp;
                if (n < 0) begin
                    if (bus.sat_mode) begin td = (c > 0); n = 0; end
                    else begin n = n + lim + 1; if (n < 0) n = 0; td = 1'b1; end
                end
            end
        end
        m_count = n;
        m_tc_up = tu;
        m_tc_dn = td;
        if (WRAP_EN && (tu || td) && m_wrap < 255) m_wrap++;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
        tick();
        tick();
        checks++;
        if (bus.count_value !== 8'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", bus.count_value);
        end
        checks++;
        if (bus.tc_up !== 1'b0 || bus.tc_dn !== 1'b0) begin
            failures++; $display("FAIL reset_tc got=%b%b exp=00", bus.tc_up, bus.tc_dn);
        end
        checks++;
        if (bus.wrap_count !== 8'd0) begin
            failures++; $display("FAIL reset_wrap got=%0d exp=0", bus.wrap_count);
        end
        checks++;
        if (bus.at_min !== 1'b1 || bus.at_max !== 1'b0) begin
            failures++; $display("FAIL reset_flags got min=%b max=%b exp min=1 max=0", bus.at_min, bus.at_max);
        end
    endtask

    task automatic test_wrap_up();
        int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 9, 1, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (bus.count_value !== 8'(exp_seq[i]) || bus.tc_up !== (exp_seq[i] == 0) || bus.tc_dn !== 1'b0) begin
                failures++;
                $display("FAIL wrap_up[%0d] got cnt=%0d up=%b dn=%b exp cnt=%0d up=%b dn=0",
                         i, bus.count_value, bus.tc_up, bus.tc_dn, exp_seq[i], exp_seq[i] == 0);
            end
        end
    endtask

    task automatic test_step_wrap_down();
        int exp_seq[4] = '{8, 4, 0, 6};
        bit exp_tc[4]  = '{1, 0, 0, 1};
        drive(0, 0, 0, 0, 1, 2, 9, 4, 0);
        tick();
        checks++;
        if (bus.count_value !== 8'd2) begin
            failures++; $display("FAIL down_preset got=%0d exp=2", bus.count_value);
        end
        drive(0, 0, 1, 0, 0, 0, 9, 4, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.count_value !== 8'(exp_seq[i]) || bus.tc_dn !== exp_tc[i] || bus.tc_up !== 1'b0) begin
                failures++;
                $display("FAIL step_wrap_down[%0d] got cnt=%0d dn=%b up=%b exp cnt=%0d dn=%b up=0",
                         i, bus.count_value, bus.tc_dn, bus.tc_up, exp_seq[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_saturate();
        bit exp_tc[3] = '{1, 0, 0};
        drive(0, 0, 0, 0, 1, 190, 200, 15, 1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 200, 15, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.count_value !== 8'd200 || bus.tc_up !== exp_tc[i] || bus.at_max !== 1'b1) begin
                failures++;
                $display("FAIL saturate[%0d] got cnt=%0d up=%b max=%b exp cnt=200 up=%b max=1",
                         i, bus.count_value, bus.tc_up, bus.at_max, exp_tc[i]);
            end
        end
    endtask

    task automatic test_priority();
        drive(0, 1, 0, 0, 1, 255, 100, 1, 0);
        tick();
        checks++;
        if (bus.count_value !== 8'd100 || bus.tc_up !== 1'b0) begin
            failures++; $display("FAIL preset_clamp got cnt=%0d up=%b exp cnt=100 up=0", bus.count_value, bus.tc_up);
        end
        drive(0, 1, 0, 1, 0, 0, 100, 1, 0);
        tick();
        checks++;
        if (bus.count_value !== 8'd100 || bus.tc_up !== 1'b0) begin
            failures++; $display("FAIL pause_hold got cnt=%0d up=%b exp cnt=100 up=0", bus.count_value, bus.tc_up);
        end
        drive(0, 1, 1, 0, 0, 0, 100, 1, 0);
        tick();
        checks++;
        if (bus.count_value !== 8'd100 || bus.tc_up !== 1'b0 || bus.tc_dn !== 1'b0) begin
            failures++; $display("FAIL updn_hold got cnt=%0d up=%b dn=%b exp cnt=100 up=0 dn=0",
                                 bus.count_value, bus.tc_up, bus.tc_dn);
        end
        drive(0, 0, 1, 0, 0, 0, 100, 0, 0);
        tick();
        checks++;
        if (bus.count_value !== 8'd100 || bus.tc_dn !== 1'b0) begin
            failures++; $display("FAIL step0_hold got cnt=%0d dn=%b exp cnt=100 dn=0", bus.count_value, bus.tc_dn);
        end
    endtask

    task automatic test_limit_change_and_reset();
        drive(0, 0, 0, 0, 1, 50, 100, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 20, 1, 0);
        tick();
        checks++;
        if (bus.count_value !== 8'd0 || bus.tc_up !== 1'b1) begin
            failures++; $display("FAIL limit_lowered got cnt=%0d up=%b exp cnt=0 up=1", bus.count_value, bus.tc_up);
        end
        // Count down past zero to get a live tc and a non-zero count, then reset against a preset.
        drive(0, 0, 1, 0, 0, 0, 20, 3, 0);
        tick();
        drive(1, 1, 0, 0, 1, 7, 20, 3, 0);
        tick();
        checks++;
        if (bus.count_value !== 8'd0 || bus.tc_up !== 1'b0 || bus.tc_dn !== 1'b0 || bus.wrap_count !== 8'd0) begin
            failures++; $display("FAIL mid_reset got cnt=%0d up=%b dn=%b wrap=%0d exp all 0",
                                 bus.count_value, bus.tc_up, bus.tc_dn, bus.wrap_count);
        end
    endtask

    task automatic test_random();
        int lim;
        drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
        tick();
        for (int i = 0; i < 600; i++) begin
            lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, int'($urandom_range(0, 255)),
                  lim, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
            tick();
            checks++;
            if (bus.count_value !== 8'(m_count)) begin
                failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, bus.count_value, m_count);
            end
            checks++;
            if (bus.tc_up !== m_tc_up[0] || bus.tc_dn !== m_tc_dn[0]) begin
                failures++; $display("FAIL rand_tc[%0d] got up=%b dn=%b exp up=%0d dn=%0d",
                                     i, bus.tc_up, bus.tc_dn, m_tc_up, m_tc_dn);
            end
            checks++;
            if (bus.at_max !== (m_count == lim) || bus.at_min !== (m_count == 0)) begin
                failures++; $display("FAIL rand_flags[%0d] got max=%b min=%b exp max=%b min=%b",
                                     i, bus.at_max, bus.at_min, m_count == lim, m_count == 0);
            end
            checks++;
            if (bus.wrap_count !== 8'(m_wrap)) begin
                failures++; $display("FAIL rand_wrap[%0d] got=%0d exp=%0d", i, bus.wrap_count, m_wrap);
            end
        end
    endtask

    task automatic test_wrap_count();
        drive(1, 0, 0, 0, 0, 0, 3, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 3, 1, 0);
        for (int i = 1; i <= 1100; i++) begin
            tick();
            checks++;
            if (bus.wrap_count !== 8'(m_wrap)) begin
                failures++; $display("FAIL wrap_track[%0d] got=%0d exp=%0d", i, bus.wrap_count, m_wrap);
            end
            if (i == 40) begin
                checks++;
                if (bus.wrap_count !== (WRAP_EN ? 8'd10 : 8'd0)) begin
                    failures++; $display("FAIL wrap_count_40 got=%0d exp=%0d", bus.wrap_count, WRAP_EN ? 10 : 0);
                end
            end
        end
        checks++;
        if (bus.wrap_count !== (WRAP_EN ? 8'd255 : 8'd0)) begin
            failures++; $display("FAIL wrap_count_sat got=%0d exp=%0d", bus.wrap_count, WRAP_EN ? 255 : 0);
        end
        // Preset must not clear the wrap counter.
        drive(0, 0, 0, 0, 1, 2, 3, 1, 0);
        tick();
        checks++;
        if (bus.wrap_count !== (WRAP_EN ? 8'd255 : 8'd0) || bus.count_value !== 8'd2) begin
            failures++; $display("FAIL wrap_after_preset got wrap=%0d cnt=%0d exp wrap=%0d cnt=2",
                                 bus.wrap_count, bus.count_value, WRAP_EN ? 255 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_step_wrap_down();
        test_saturate();
        test_priority();
        test_limit_change_and_reset();
        test_random();
        test_wrap_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
